decode_scoreboard: RTL and testbench
====================================

Name: decode_scoreboard

Overview:
- Register-dependency scoreboard for the Decode stage of the 64-bit pipelined core.
- Tracks in-flight writes to each of the 32 architectural registers and stalls Decode while a source register (RA1D/RA2D) still has a pending write.
- Releases a register when Writeback retires the write, or when a squashed instruction cancels it.
- Also keeps a stall performance counter and a sticky underflow error flag.

Parameters:
- NREGS, 32, number of tracked registers; address width is 5 bits.
- CNT_W, 2, width of each per-register pending counter; MAX = 2^CNT_W-1.
- PERF_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  a valid instruction is in Decode this cycle.
- issue_we  in  1  the Decode instruction writes a register.
- issue_rd  in  5  destination register of the Decode instruction.
- use_ra1  in  1  the instruction reads ra1.
- use_ra2  in  1  the instruction reads ra2.
- ra1  in  5  source register 1, same value as RA1D.
- ra2  in  5  source register 2, same value as RA2D.
- retire_valid  in  1  Writeback commits a register write this cycle (RegWriteW).
- retire_rd  in  5  register written by Writeback (WA3W).
- cancel_valid  in  1  a squashed in-flight writer is being discarded.
- cancel_rd  in  5  destination register of the squashed writer.
- clr_perf  in  1  synchronous clear of stall_cycles.
- stall  out  1  hold Decode/Fetch and insert a bubble into Execute.
- busy_vec  out  NREGS  bit r = (pending[r] != 0), taken from registered state.
- underflow_err  out  1  sticky flag: a decrement was attempted on a zero counter.
- stall_cycles  out  PERF_W  saturating count of cycles with stall=1.

Behaviour:
- Reset (asynchronous): all pending[r]=0, underflow_err=0, stall_cycles=0. Therefore busy_vec=0 and stall=0.
- busy(x), combinational: (pending[x]!=0) and not (pending[x]==1 and a release of x occurs this cycle, counting retire or cancel). This is a same-cycle bypass, which is valid because the register file writes on the falling clock edge.
- Register 31 is tracked like any other register. The link write (PCPlus8 via MemToRegW) is reported through retire_rd=31.
- stall = issue_valid and ((use_ra1 and busy(ra1)) or (use_ra2 and busy(ra2)) or (issue_we and pending[issue_rd]==MAX)).
- stall is purely combinational from registered state and the current inputs. It adds zero latency.
- inc = issue_valid and issue_we and not stall. When inc=1, issue_rd is incremented at the next edge.
- dec_r = retire_valid for retire_rd, plus cancel_valid for cancel_rd. This gives 0, 1 or 2 decrements per register per cycle.
- Next value per register: pending[r] + inc_r - dec_r, evaluated as a single net update. Consequences:
  - Issue and retire on the same register in the same cycle leave the value unchanged.
  - Retire and cancel on the same register decrement by 2.
- Underflow: if the net result would go below 0, the counter clamps to 0 and underflow_err is set. underflow_err holds until reset.
- Overflow cannot occur, because stall blocks an issue when the counter is at MAX.
- stall_cycles:
  - Increments on each rising edge where stall=1, saturating at all-ones.
  - clr_perf takes priority: the counter becomes 0 at that edge, regardless of stall.
- reset asserted mid-operation clears everything immediately. In-flight retires arriving after reset deassertion are counted as underflows; the pipeline is flushed together with reset.
- A read of a register with pending write causes no stall when the corresponding use_raX=0.
- Inputs with issue_valid=0 cause no increment and no stall. Retire and cancel are still processed.

Test Plan:
- Reset, then issue r5 write (issue_valid=1, issue_we=1, issue_rd=5) -> next cycle busy_vec=0x0000_0020, stall=0 on that issue cycle.
- With pending[5]=1, issue use_ra1=1, ra1=5 for 3 cycles, then retire_rd=5 in cycle 3:
  - cycles 1-2: stall=1.
  - cycle 3: stall=0 via the bypass.
  - Afterwards: pending[5]=0 and stall_cycles=2.
- Same cycle issue_we to r7 and retire r7 with pending[7]=1 -> pending[7] stays 1, busy_vec[7]=1, stall=0.
- Issue r3 three times (CNT_W=2), then a fourth issue to r3 -> 4th cycle stall=1, pending[3]=3. After one retire of r3 the issue proceeds; pending[3] ends at 3.
- pending[9]=2 with retire_rd=9 and cancel_rd=9 in the same cycle -> pending[9]=0, underflow_err=0. A further retire of r9 -> underflow_err=1 and it stays 1.
- Force stall for 70000 cycles (PERF_W=16) -> stall_cycles=0xFFFF. Pulse clr_perf -> stall_cycles=0. Assert reset asynchronously mid-stall -> outputs clear before the next clock edge.

Source files
------------

// File: rtl/decode_scoreboard_if.sv
// Decode/Writeback handshake bundle for the register-dependency scoreboard.
interface decode_scoreboard_if #(
  parameter int NREGS  = 32,
  parameter int PERF_W = 16
);
  localparam int AW = $clog2(NREGS);

  logic              issue_valid;
  logic              issue_we;
  logic [AW-1:0]     issue_rd;
  logic              use_ra1;
  logic              use_ra2;
  logic [AW-1:0]     ra1;
  logic [AW-1:0]     ra2;
  logic              retire_valid;
  logic [AW-1:0]     retire_rd;
  logic              cancel_valid;
  logic [AW-1:0]     cancel_rd;
  logic              clr_perf;
  logic              stall;
  logic [NREGS-1:0]  busy_vec;
  logic              underflow_err;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output issue_valid, issue_we, issue_rd, use_ra1, use_ra2, ra1, ra2,
           retire_valid, retire_rd, cancel_valid, cancel_rd, clr_perf,
    input  stall, busy_vec, underflow_err, stall_cycles
  );

  modport slave (
    input  issue_valid, issue_we, issue_rd, use_ra1, use_ra2, ra1, ra2,
           retire_valid, retire_rd, cancel_valid, cancel_rd, clr_perf,
    output stall, busy_vec, underflow_err, stall_cycles
  );
endinterface

// File: rtl/decode_scoreboard.sv
// Per-register pending-write counters; stalls Decode on RAW hazards and on a
// saturated destination counter, with a same-cycle bypass for releases.
module decode_scoreboard #(
  parameter int NREGS  = 32,
  parameter int CNT_W  = 2,
  parameter int PERF_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  decode_scoreboard_if.slave sb
);
  localparam int AW = $clog2(NREGS);
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [NREGS-1:0][CNT_W-1:0] pend_q, pend_d;
  logic [NREGS-1:0]            uf_r;
  logic                        uf_q, uf_d;
  logic [PERF_W-1:0]           perf_q, perf_d;
  logic                        stall, inc;
  logic                        busy1, busy2, full;

  function automatic logic busy_of(
    input logic [NREGS-1:0][CNT_W-1:0] p,
    input logic [AW-1:0] x,
    input logic rv, input logic [AW-1:0] rr,
    input logic cv, input logic [AW-1:0] cr
  );
    logic rel;
    rel = (rv && rr == x) || (cv && cr == x);
    // Register file writes on the falling edge, so a final release this
    // cycle makes the value readable in Decode now.
    return (p[x] != '0) && !((p[x] == ONE) && rel);
  endfunction

  always_comb begin
    busy1 = busy_of(pend_q, sb.ra1, sb.retire_valid, sb.retire_rd,
                    sb.cancel_valid, sb.cancel_rd);
    busy2 = busy_of(pend_q, sb.ra2, sb.retire_valid, sb.retire_rd,
                    sb.cancel_valid, sb.cancel_rd);
    full  = (pend_q[sb.issue_rd] == MAX);
    stall = sb.issue_valid && ((sb.use_ra1 && busy1) || (sb.use_ra2 && busy2) ||
                               (sb.issue_we && full));
    inc   = sb.issue_valid && sb.issue_we && !stall;
  end

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    logic             inc_r;
    logic [1:0]       dec_r;
    logic [CNT_W+1:0] sum;

    always_comb begin
      inc_r = inc && (sb.issue_rd == AW'(r));
      dec_r = {1'b0, sb.retire_valid && (sb.retire_rd == AW'(r))} +
              {1'b0, sb.cancel_valid && (sb.cancel_rd == AW'(r))};
      sum   = {2'b00, pend_q[r]} + {{(CNT_W+1){1'b0}}, inc_r} - {{CNT_W{1'b0}}, dec_r};
      // Top bit set means the net result went negative: clamp and flag.
      uf_r[r]  = sum[CNT_W+1];
      pend_d[r] = uf_r[r] ? '0 : sum[CNT_W-1:0];
    end
  end

  always_comb begin
    uf_d = uf_q || (|uf_r);
    if (sb.clr_perf)                 perf_d = '0;
    else if (stall && !(&perf_q))    perf_d = perf_q + PERF_W'(1);
    else                             perf_d = perf_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      uf_q   <= 1'b0;
      perf_q <= '0;
    end else begin
      pend_q <= pend_d;
      uf_q   <= uf_d;
      perf_q <= perf_d;
    end
  end

  for (genvar r = 0; r < NREGS; r++) begin : g_busy
    assign sb.busy_vec[r] = (pend_q[r] != '0);
  end

  assign sb.stall         = stall;
  assign sb.underflow_err = uf_q;
  assign sb.stall_cycles  = perf_q;
endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed-vector bench for decode_scoreboard with hand-computed expectations.
module tb_decode_scoreboard;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  decode_scoreboard_if #(.NREGS(32), .PERF_W(16)) sbif ();

  decode_scoreboard #(.NREGS(32), .CNT_W(2), .PERF_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sbif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    sbif.issue_valid  = 1'b0;
    sbif.issue_we     = 1'b0;
    sbif.issue_rd     = '0;
    sbif.use_ra1      = 1'b0;
    sbif.use_ra2      = 1'b0;
    sbif.ra1          = '0;
    sbif.ra2          = '0;
    sbif.retire_valid = 1'b0;
    sbif.retire_rd    = '0;
    sbif.cancel_valid = 1'b0;
    sbif.cancel_rd    = '0;
    sbif.clr_perf     = 1'b0;
  endtask

  // Advance one edge; inputs are then changed 1ns after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_wr(input logic [4:0] rd);
    sbif.issue_valid = 1'b1;
    sbif.issue_we    = 1'b1;
    sbif.issue_rd    = rd;
  endtask

  task automatic retire(input logic [4:0] rd);
    sbif.retire_valid = 1'b1;
    sbif.retire_rd    = rd;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    idle();
    reset = 1'b1;
    #3;
    chk("rst_busy", sbif.busy_vec, 32'h0);
    chk("rst_stall", {31'b0, sbif.stall}, 32'h0);
    chk("rst_uf", {31'b0, sbif.underflow_err}, 32'h0);
    chk("rst_perf", {16'b0, sbif.stall_cycles}, 32'h0);
    cyc();
    reset = 1'b0;
    cyc();

    // Issue write to r5
    issue_wr(5'd5);
    #1 chk("iss5_stall", {31'b0, sbif.stall}, 32'h0);
    cyc(); idle();
    #1 chk("iss5_busy", sbif.busy_vec, 32'h0000_0020);

    // RAW on r5: two stalled cycles, then bypass on retire
    sbif.issue_valid = 1'b1; sbif.use_ra1 = 1'b1; sbif.ra1 = 5'd5;
    #1 chk("raw_c1", {31'b0, sbif.stall}, 32'h1);
    cyc();
    #1 chk("raw_c2", {31'b0, sbif.stall}, 32'h1);
    cyc();
    retire(5'd5);
    #1 chk("raw_c3_bypass", {31'b0, sbif.stall}, 32'h0);
    cyc(); idle();
    #1 chk("raw_busy", sbif.busy_vec, 32'h0);
    chk("raw_perf", {16'b0, sbif.stall_cycles}, 32'd2);

    // Issue + retire r7 same cycle keeps count at 1
    issue_wr(5'd7);
    cyc(); idle();
    sbif.issue_valid = 1'b1; sbif.ra2 = 5'd7; sbif.use_ra2 = 1'b0;
    #1 chk("no_use_nostall", {31'b0, sbif.stall}, 32'h0);
    issue_wr(5'd7); retire(5'd7);
    #1 chk("iss_ret7_stall", {31'b0, sbif.stall}, 32'h0);
    cyc(); idle();
    #1 chk("iss_ret7_busy", {31'b0, sbif.busy_vec[7]}, 32'h1);
    retire(5'd7);
    cyc(); idle();
    #1 chk("r7_drained", sbif.busy_vec, 32'h0);
    chk("r7_uf", {31'b0, sbif.underflow_err}, 32'h0);

    // issue_valid=0 never increments
    sbif.issue_we = 1'b1; sbif.issue_rd = 5'd12;
    cyc(); idle();
    #1 chk("novalid_busy", sbif.busy_vec, 32'h0);

    // Saturate r3 at MAX=3
    for (int i = 0; i < 3; i++) begin
      issue_wr(5'd3);
      #1 chk($sformatf("r3_iss%0d", i), {31'b0, sbif.stall}, 32'h0);
      cyc();
    end
    #1 chk("r3_full_stall", {31'b0, sbif.stall}, 32'h1);
    cyc();
    retire(5'd3);
    #1 chk("r3_full_ret_stall", {31'b0, sbif.stall}, 32'h1);
    cyc();
    sbif.retire_valid = 1'b0;
    #1 chk("r3_proceed", {31'b0, sbif.stall}, 32'h0);
    cyc();
    #1 chk("r3_full_again", {31'b0, sbif.stall}, 32'h1);
    idle();
    #1 chk("r3_perf", {16'b0, sbif.stall_cycles}, 32'd4);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("r3_busy_d%0d", i), {31'b0, sbif.busy_vec[3]}, 32'h1);
      retire(5'd3);
      cyc(); idle();
    end
    #1 chk("r3_drained", sbif.busy_vec, 32'h0);
    chk("r3_uf", {31'b0, sbif.underflow_err}, 32'h0);

    // Cancel also bypasses
    issue_wr(5'd10);
    cyc(); idle();
    sbif.issue_valid = 1'b1; sbif.use_ra2 = 1'b1; sbif.ra2 = 5'd10;
    #1 chk("r10_stall", {31'b0, sbif.stall}, 32'h1);
    sbif.cancel_valid = 1'b1; sbif.cancel_rd = 5'd10;
    #1 chk("r10_cancel_bypass", {31'b0, sbif.stall}, 32'h0);
    cyc(); idle();
    #1 chk("r10_busy", sbif.busy_vec, 32'h0);

    // Double release on r9, then underflow
    issue_wr(5'd9); cyc(); cyc(); idle();
    #1 chk("r9_busy", sbif.busy_vec, 32'h0000_0200);
    retire(5'd9); sbif.cancel_valid = 1'b1; sbif.cancel_rd = 5'd9;
    cyc(); idle();
    #1 chk("r9_dbl_busy", sbif.busy_vec, 32'h0);
    chk("r9_dbl_uf", {31'b0, sbif.underflow_err}, 32'h0);
    retire(5'd9);
    cyc(); idle();
    #1 chk("r9_uf_set", {31'b0, sbif.underflow_err}, 32'h1);
    chk("r9_uf_clamp", sbif.busy_vec, 32'h0);
    cyc();
    chk("r9_uf_sticky", {31'b0, sbif.underflow_err}, 32'h1);

    // Saturating perf counter
    issue_wr(5'd1); cyc(); idle();
    sbif.issue_valid = 1'b1; sbif.use_ra1 = 1'b1; sbif.ra1 = 5'd1;
    repeat (70000) cyc();
    #1 chk("perf_sat", {16'b0, sbif.stall_cycles}, 32'h0000_FFFF);
    sbif.clr_perf = 1'b1;
    cyc();
    sbif.clr_perf = 1'b0;
    #1 chk("perf_clr", {16'b0, sbif.stall_cycles}, 32'h0);
    cyc();
    chk("perf_after_clr", {16'b0, sbif.stall_cycles}, 32'h1);

    // Async reset mid-stall, checked before the next edge
    reset = 1'b1;
    #1;
    chk("arst_busy", sbif.busy_vec, 32'h0);
    chk("arst_stall", {31'b0, sbif.stall}, 32'h0);
    chk("arst_uf", {31'b0, sbif.underflow_err}, 32'h0);
    chk("arst_perf", {16'b0, sbif.stall_cycles}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
